ssd_scan_ctrl: RTL
==================

Name: ssd_scan_ctrl

Overview:
Parametrised N-digit seven-segment display controller with keypad entry buffer. Accepts single-cycle key events from the keypad decoder path and shifts hex digits into a right-entry buffer; supports backspace and clear. Time-multiplexes the buffer onto one shared segment bus plus a digit-select index, replacing manual chip-select toggling with an automatic refresh scan. Unentered leading digits are blanked.

Parameters:
clk_freq, 125_000_000, input clock frequency in Hz
refresh_hz, 1000, full-display refresh rate in Hz (all digits once per period)
num_digits, 2, number of multiplexed digits (>=2)
seg_active_low, 0, 1 = segment lines lit when driven low; 0 = lit when high
sel_w, $clog2(num_digits), width of digit index (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_valid  input  1  single-cycle pulse: key_code is a new digit
key_code  input  4  hex value of pressed key (0x0-0xF)
key_bksp  input  1  single-cycle pulse: delete most recent digit
key_clr  input  1  single-cycle pulse: clear buffer
disp_en  input  1  0 = blank all segments (scan continues)
seg  output  7  segment drive {g,f,e,d,c,b,a}, polarity per seg_active_low
dig_sel  output  sel_w  index of digit currently driven (0 = rightmost)
digits  output  4*num_digits  buffer contents, digit i at [4i+3:4i]
entry_count  output  sel_w+1  number of valid entered digits, 0..num_digits
full  output  1  high when entry_count == num_digits

Behaviour:
- Reset (rst=1 at clk edge): digits=0, entry_count=0, full=0, dig_sel=0, scan counter=0, seg=blank (7'h00 if seg_active_low=0, 7'h7F otherwise). Reset overrides every other input.
- Scan: scan_div = clk_freq/(refresh_hz*num_digits), integer division, minimum 1. Counter counts 0..scan_div-1; on terminal count it returns to 0 and dig_sel increments, wrapping num_digits-1 -> 0.
- seg is registered, computed from the next dig_sel value, so seg and dig_sel always change on the same edge (no ghost cycle).
- Digit i is lit iff disp_en=1 and i < entry_count; otherwise blank.
- Hex encoding (active-high form; invert all 7 bits when seg_active_low=1): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- key_valid: digits shifts left one nibble, digit 0 <= key_code; digit num_digits-1 is discarded when full. entry_count increments, saturating at num_digits. Buffer updates on the edge where key_valid is sampled high.
- key_bksp: digits shifts right one nibble, top digit <= 0; entry_count decrements. When entry_count=0 it is a no-op.
- key_clr: digits=0, entry_count=0. Scan is unaffected.
- Priority when pulses coincide: key_clr > key_valid > key_bksp; lower-priority events in the same cycle are dropped.
- full is combinational from entry_count.
- seg reflects a buffer change at the next scan edge, at most scan_div cycles later. digits/entry_count reflect it one cycle after the event.
- Inputs are held as sampled. Debouncing and pulse generation are upstream.

Test Plan:
1. Params clk_freq=800, refresh_hz=100, num_digits=2 (scan_div=4). Release rst with disp_en=1 -> dig_sel sequence 0,0,0,0,1,1,1,1,0...; seg=00 throughout because entry_count=0.
2. key_valid with code 3, then code A -> digits=8'h3A, entry_count=2, full=1; seg=77 while dig_sel=0 and 4F while dig_sel=1.
3. From state 2, key_valid code 5 -> digits=8'hA5, entry_count stays 2; then key_bksp -> digits=8'h0A, entry_count=1; seg=77 at dig_sel=0 and 00 at dig_sel=1.
4. key_clr and key_valid asserted in the same cycle (code 7) -> digits=0, entry_count=0. key_valid(7) and key_bksp asserted together with count=0 -> digits=8'h07, count=1.
5. seg_active_low=1, one entry of code 8: seg=00 at dig_sel=0 and 7F at blank digit 1; drop disp_en -> seg=7F on every subsequent scan edge.
6. Assert rst mid-scan (counter=2, dig_sel=1, count=2) -> next edge: dig_sel=0, counter=0, digits=0, entry_count=0, seg=blank; scan resumes 4 cycles per digit.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: keypad entry buffer with a multiplexed seven-segment refresh scan
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   key_valid, key_code    new hex digit, shifted in at the right
//   key_bksp, key_clr      delete the newest digit / clear the buffer
//   disp_en                0 blanks the segments while the scan keeps running
//   seg, dig_sel           shared segment bus and index of the driven digit
//   digits, entry_count    buffer contents and number of entered digits
//   full                   buffer holds num_digits entries
module ssd_scan_ctrl #(
    parameter int clk_freq       = 125_000_000,
    parameter int refresh_hz     = 1000,
    parameter int num_digits     = 2,
    parameter int seg_active_low = 0,
    parameter int sel_w          = $clog2(num_digits)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    key_bksp,
    input  logic                    key_clr,
    input  logic                    disp_en,
    output logic [6:0]              seg,
    output logic [sel_w-1:0]        dig_sel,
    output logic [4*num_digits-1:0] digits,
    output logic [sel_w:0]          entry_count,
    output logic                    full
);
    localparam int scan_div_raw = clk_freq / (refresh_hz * num_digits);
    localparam int scan_div = scan_div_raw < 1 ? 1 : scan_div_raw;
    localparam int cnt_w = scan_div > 1 ? $clog2(scan_div) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(scan_div - 1);
    localparam logic [sel_w-1:0] sel_max = sel_w'(num_digits - 1);
    localparam logic [sel_w:0] cnt_full = (sel_w+1)'(num_digits);
    localparam logic [6:0] blank = seg_active_low != 0 ? 7'h7F : 7'h00;
    localparam logic [6:0] hex_lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [cnt_w-1:0] scan_cnt;
    logic             tc;
    logic [sel_w-1:0] sel_nxt;
    logic [3:0]       nib;
    logic             lit;
    logic [6:0]       hex;

    assign tc = scan_cnt == cnt_max;
    assign sel_nxt = !tc ? dig_sel : (dig_sel == sel_max ? '0 : dig_sel + sel_w'(1));
    // seg is decoded for the digit about to be selected so both change on one edge
    assign nib = digits[4*sel_nxt +: 4];
    assign lit = disp_en && ({1'b0, sel_nxt} < entry_count);
    assign hex = hex_lut[nib];
    assign full = entry_count == cnt_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            dig_sel     <= '0;
            seg         <= blank;
            digits      <= '0;
            entry_count <= '0;
        end else begin
            scan_cnt <= tc ? '0 : scan_cnt + cnt_w'(1);
            dig_sel  <= sel_nxt;
            if (tc)
                seg <= lit ? (seg_active_low != 0 ? ~hex : hex) : blank;
            if (key_clr) begin
                digits      <= '0;
                entry_count <= '0;
            end else if (key_valid) begin
                digits <= {digits[4*num_digits-5:0], key_code};
                if (!full)
                    entry_count <= entry_count + (sel_w+1)'(1);
            end else if (key_bksp && entry_count != '0) begin
                digits      <= {4'h0, digits[4*num_digits-1:4]};
                entry_count <= entry_count - (sel_w+1)'(1);
            end
        end
    end
endmodule
